ex_alu_rglr_pipe: RTL and testbench
===================================

EX_ALU_RGLR_PIPE -- requirements
Module: ex_alu_rglr_pipe

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width (32 or 64) | PC_SIZE, 32, PC width (<= XLEN) | TAG_W, 5, passthrough tag (rd index) width | DEPTH, 2, output buffer entries (>= 1).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 alu_i_valid  in  1  request valid.
REQ-005 alu_i_ready  out  1  request accepted when valid & ready at a rising edge.
REQ-006 alu_i_op  in  4  operation code: ADD=0 SUB=1 XOR=2 SLL=3 SRL=4 SRA=5 OR=6 AND=7 SLT=8 SLTU=9 LUI=10; 11-15 illegal.
REQ-007 alu_i_op1pc, alu_i_op2imm, alu_i_word  in  1 each  op1 = zero-extended PC; op2 = imm; 32-bit word op (ignored when XLEN=32).
REQ-008 alu_i_nop, alu_i_ecall, alu_i_ebreak, alu_i_wfi  in  1 each  decode flags.
REQ-009 alu_i_rs1, alu_i_rs2, alu_i_imm  in  XLEN each; alu_i_pc  in  PC_SIZE; alu_i_tag  in  TAG_W.
REQ-010 alu_o_valid  out  1; alu_o_ready  in  1  writeback handshake.
REQ-011 alu_o_wbck_wdat  out  XLEN; alu_o_tag  out  TAG_W; alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi, alu_o_illegal  out  1 each.
REQ-012 alu_flush  in  1  discard all buffered results.

Function
REQ-013 Block SHALL compute internally (no shared datapath): op1 = op1pc ? pc : rs1; op2 = op2imm ? imm : rs2.
REQ-014 ADD/SUB SHALL wrap modulo 2^XLEN; XOR/OR/AND bitwise; LUI result = op2.
REQ-015 Shift amount SHALL be op2[log2(XLEN)-1:0]; SRA arithmetic, SRL logical.
REQ-016 SLT signed, SLTU unsigned compare; result 1 or 0 zero-extended.
REQ-017 When XLEN=64 and word=1: ADD/SUB/SLL/SRL/SRA SHALL operate on low 32 bits, shift amount op2[4:0], result sign-extended from bit 31; word with other ops SHALL be ignored.
REQ-018 nop=1 SHALL force result 0 regardless of op.
REQ-019 Illegal op SHALL force result 0 and set alu_o_illegal.
REQ-020 alu_o_wbck_err = ecall | ebreak | wfi | illegal, stored per entry.
REQ-021 Accepted requests SHALL be written into a DEPTH-entry FIFO holding {result, tag, ecall, ebreak, wfi, illegal}; latency exactly 1 cycle (accept at edge N, alu_o_valid high after edge N).
REQ-022 alu_o_valid = (occupancy != 0); outputs reflect head entry; head SHALL remain stable while valid & ~ready.
REQ-023 alu_i_ready = (occupancy < DEPTH) | alu_o_ready; simultaneous push and pop when full SHALL be allowed, occupancy unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH (DEPTH need not be a power of two); occupancy counter 0..DEPTH, never over/underflows.
REQ-025 Results SHALL leave in acceptance order.
REQ-026 alu_flush=1 at an edge SHALL set occupancy and pointers to 0; a push or pop in the same cycle SHALL be discarded; alu_i_ready unaffected by flush.
REQ-027 Outputs when alu_o_valid=0 SHALL be 0 (data, tag, flags).

Reset
REQ-028 rst asserted SHALL immediately clear occupancy, pointers: alu_o_valid=0, all data/flag outputs 0, alu_i_ready=1.
REQ-029 Reset mid-transfer SHALL lose all buffered entries; first accept after deassertion behaves as from empty.
REQ-030 FIFO data storage need not be reset; only control state.

Structure
REQ-031 Op-code constants (ADD..LUI, width 4) SHALL live in the shared defines package alongside existing decode-info constants.
REQ-032 Arithmetic/logic core SHALL be one combinational sub-module ex_alu_rglr_core (params XLEN); FIFO control stays in top.

Verification
REQ-033 XLEN=32: ADD rs1=0xFFFFFFFF, rs2=1 -> wdat=0x00000000 one cycle later, err=0.
REQ-034 XLEN=64: SRA word=1, rs1=0x0000_0000_8000_0000, imm shift 4, op2imm=1 -> wdat=0xFFFF_FFFF_F800_0000.
REQ-035 SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU same operands -> 0; op=12 -> wdat=0, illegal=1, err=1.
REQ-036 DEPTH=2, alu_o_ready=0, push tags 1,2 -> alu_i_ready=0 unless ready; raise ready with 3rd valid -> tags pop 1,2,3 in order, no loss.
REQ-037 Two entries buffered, alu_flush=1 with valid push same cycle -> alu_o_valid=0 next cycle, pushed entry absent.
REQ-038 rst asserted between clock edges with 1 entry held -> alu_o_valid drops before next edge; post-reset ADD 2+3 -> 5.

Source files
------------

// File: rtl/ex_alu_rglr_pipe_pkg.sv
// ex_alu_rglr_pipe_pkg: shared ALU op codes and decode-info helpers
package ex_alu_rglr_pipe_pkg;
  localparam int DEC_ALU_OP_W = 4;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_XOR  = 4'd2;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SLL  = 4'd3;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SRL  = 4'd4;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SRA  = 4'd5;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_OR   = 4'd6;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_AND  = 4'd7;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_SLTU = 4'd9;
  localparam logic [DEC_ALU_OP_W-1:0] ALU_LUI  = 4'd10;

  function automatic logic alu_op_legal(input logic [DEC_ALU_OP_W-1:0] op);
    return op <= ALU_LUI;
  endfunction

  function automatic logic alu_op_wordable(input logic [DEC_ALU_OP_W-1:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction
endpackage

// File: rtl/ex_alu_rglr_pipe_core.sv
// ex_alu_rglr_core: combinational ALU (op, word, nop, op1, op2 -> res, illegal)
module ex_alu_rglr_core
  import ex_alu_rglr_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [DEC_ALU_OP_W-1:0] op,
  input  logic                    word,
  input  logic                    nop,
  input  logic [XLEN-1:0]         op1,
  input  logic [XLEN-1:0]         op2,
  output logic [XLEN-1:0]         res,
  output logic                    illegal
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  logic [XLEN-1:0] full, full_sra;
  logic signed [31:0] w, w_sra;
  logic use_w;
  always_comb begin
    sh = op2[SW-1:0];
    illegal = !alu_op_legal(op);
    use_w = (XLEN == 64) && word && alu_op_wordable(op);
    full_sra = $signed(op1) >>> sh;
    w_sra = $signed(op1[31:0]) >>> op2[4:0];
    case (op)
      ALU_SUB:  full = op1 - op2;
      ALU_XOR:  full = op1 ^ op2;
      ALU_SLL:  full = op1 << sh;
      ALU_SRL:  full = op1 >> sh;
      ALU_SRA:  full = full_sra;
      ALU_OR:   full = op1 | op2;
      ALU_AND:  full = op1 & op2;
      ALU_SLT:  full = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU: full = XLEN'(op1 < op2);
      ALU_LUI:  full = op2;
      default:  full = op1 + op2;
    endcase
    w = op == ALU_SUB ? op1[31:0] - op2[31:0] :
        op == ALU_SLL ? op1[31:0] << op2[4:0] :
        op == ALU_SRL ? op1[31:0] >> op2[4:0] :
        op == ALU_SRA ? w_sra : op1[31:0] + op2[31:0];
    res = (nop || illegal) ? '0 : use_w ? XLEN'(w) : full;
  end
endmodule

// File: rtl/ex_alu_rglr_pipe.sv
// ex_alu_rglr_pipe: ALU with DEPTH-entry result FIFO; alu_i_* request in, alu_o_* writeback out, alu_flush drops buffer
module ex_alu_rglr_pipe
  import ex_alu_rglr_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_i_valid,
  output logic                    alu_i_ready,
  input  logic [DEC_ALU_OP_W-1:0] alu_i_op,
  input  logic                    alu_i_op1pc,
  input  logic                    alu_i_op2imm,
  input  logic                    alu_i_word,
  input  logic                    alu_i_nop,
  input  logic                    alu_i_ecall,
  input  logic                    alu_i_ebreak,
  input  logic                    alu_i_wfi,
  input  logic [XLEN-1:0]         alu_i_rs1,
  input  logic [XLEN-1:0]         alu_i_rs2,
  input  logic [XLEN-1:0]         alu_i_imm,
  input  logic [PC_SIZE-1:0]      alu_i_pc,
  input  logic [TAG_W-1:0]        alu_i_tag,
  output logic                    alu_o_valid,
  input  logic                    alu_o_ready,
  output logic [XLEN-1:0]         alu_o_wbck_wdat,
  output logic [TAG_W-1:0]        alu_o_tag,
  output logic                    alu_o_wbck_err,
  output logic                    alu_o_cmt_ecall,
  output logic                    alu_o_cmt_ebreak,
  output logic                    alu_o_cmt_wfi,
  output logic                    alu_o_illegal,
  input  logic                    alu_flush
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ecall;
    logic             ebreak;
    logic             wfi;
    logic             illegal;
  } ent_t;
  ent_t mem_q [DEPTH];
  ent_t ent_d, head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop, ill;
  logic [XLEN-1:0] op1, op2, res;

  assign op1 = alu_i_op1pc ? XLEN'(alu_i_pc) : alu_i_rs1;
  assign op2 = alu_i_op2imm ? alu_i_imm : alu_i_rs2;

  ex_alu_rglr_core #(.XLEN(XLEN)) u_core (
    .op(alu_i_op), .word(alu_i_word), .nop(alu_i_nop),
    .op1(op1), .op2(op2), .res(res), .illegal(ill)
  );

  always_comb begin
    alu_o_valid = cnt_q != '0;
    alu_i_ready = cnt_q < CW'(DEPTH) || alu_o_ready;
    push = alu_i_valid && alu_i_ready;
    pop = alu_o_valid && alu_o_ready;
    ent_d = '{res, alu_i_tag, alu_i_ecall, alu_i_ebreak, alu_i_wfi, ill};
    wr_d = alu_flush ? '0 : !push ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d = alu_flush ? '0 : !pop ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    cnt_d = alu_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    head = alu_o_valid ? mem_q[rd_q] : '0;
    alu_o_wbck_wdat = head.res;
    alu_o_tag = head.tag;
    alu_o_cmt_ecall = head.ecall;
    alu_o_cmt_ebreak = head.ebreak;
    alu_o_cmt_wfi = head.wfi;
    alu_o_illegal = head.illegal;
    alu_o_wbck_err = head.ecall | head.ebreak | head.wfi | head.illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !alu_flush) mem_q[wr_q] <= ent_d;
  end
endmodule

// File: tb/tb_ex_alu_rglr_pipe.sv
// tb_ex_alu_rglr_pipe: scoreboard bench for ex_alu_rglr_pipe at XLEN=64, DEPTH=2
module tb_ex_alu_rglr_pipe;
  logic clk = 0, rst = 1;
  logic alu_i_valid = 0, alu_i_ready;
  logic [3:0] alu_i_op = 0;
  logic alu_i_op1pc = 0, alu_i_op2imm = 0, alu_i_word = 0;
  logic alu_i_nop = 0, alu_i_ecall = 0, alu_i_ebreak = 0, alu_i_wfi = 0;
  logic [63:0] alu_i_rs1 = 0, alu_i_rs2 = 0, alu_i_imm = 0;
  logic [31:0] alu_i_pc = 0;
  logic [4:0] alu_i_tag = 0;
  logic alu_o_valid, alu_o_ready = 1;
  logic [63:0] alu_o_wbck_wdat;
  logic [4:0] alu_o_tag;
  logic alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi, alu_o_illegal;
  logic alu_flush = 0;

  typedef struct { logic [63:0] d; logic [4:0] tag; logic [4:0] fl; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;

  ex_alu_rglr_pipe #(.XLEN(64), .PC_SIZE(32), .TAG_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready), .alu_i_op(alu_i_op),
    .alu_i_op1pc(alu_i_op1pc), .alu_i_op2imm(alu_i_op2imm), .alu_i_word(alu_i_word),
    .alu_i_nop(alu_i_nop), .alu_i_ecall(alu_i_ecall), .alu_i_ebreak(alu_i_ebreak), .alu_i_wfi(alu_i_wfi),
    .alu_i_rs1(alu_i_rs1), .alu_i_rs2(alu_i_rs2), .alu_i_imm(alu_i_imm), .alu_i_pc(alu_i_pc),
    .alu_i_tag(alu_i_tag), .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready),
    .alu_o_wbck_wdat(alu_o_wbck_wdat), .alu_o_tag(alu_o_tag), .alu_o_wbck_err(alu_o_wbck_err),
    .alu_o_cmt_ecall(alu_o_cmt_ecall), .alu_o_cmt_ebreak(alu_o_cmt_ebreak), .alu_o_cmt_wfi(alu_o_cmt_wfi),
    .alu_o_illegal(alu_o_illegal), .alu_flush(alu_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] w;
    if (word && (op <= 1 || (op >= 3 && op <= 5))) begin
      case (op)
        0: w = a[31:0] + b[31:0];
        1: w = a[31:0] - b[31:0];
        3: w = a[31:0] << b[4:0];
        4: w = a[31:0] >> b[4:0];
        default: w = $signed(a[31:0]) >>> b[4:0];
      endcase
      return {{32{w[31]}}, w};
    end
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a ^ b;
      3: r = a << b[5:0];
      4: r = a >> b[5:0];
      5: r = $signed(a) >>> b[5:0];
      6: r = a | b;
      7: r = a & b;
      8: r = {63'b0, $signed(a) < $signed(b)};
      9: r = {63'b0, a < b};
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic exp_t expect_now();
    exp_t x;
    logic ill;
    logic [63:0] a, b;
    a = alu_i_op1pc ? {32'b0, alu_i_pc} : alu_i_rs1;
    b = alu_i_op2imm ? alu_i_imm : alu_i_rs2;
    ill = alu_i_op > 4'd10;
    x.d = (ill || alu_i_nop) ? 64'd0 : model(alu_i_op, alu_i_word, a, b);
    x.tag = alu_i_tag;
    x.fl = {alu_i_ecall | alu_i_ebreak | alu_i_wfi | ill, alu_i_ecall, alu_i_ebreak, alu_i_wfi, ill};
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst || alu_flush) q.delete();
    else begin
      if (!alu_o_valid) begin
        check("idle_dat", alu_o_wbck_wdat, 64'd0);
        check("idle_tf", 64'({alu_o_tag, alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi, alu_o_illegal}), 64'd0);
      end
      if (alu_o_valid && alu_o_ready) begin
        if (q.size() == 0) check("pop_empty", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          check("wdat", alu_o_wbck_wdat, e.d);
          check("tag_flags", 64'({alu_o_tag, alu_o_wbck_err, alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi, alu_o_illegal}), 64'({e.tag, e.fl}));
        end
      end
      if (alu_i_valid && alu_i_ready) q.push_back(expect_now());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] m, input logic [3:0] f,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm, input logic [4:0] tag);
    {alu_i_word, alu_i_op1pc, alu_i_op2imm} = m;
    {alu_i_nop, alu_i_ecall, alu_i_ebreak, alu_i_wfi} = f;
    alu_i_op = op;
    alu_i_rs1 = rs1;
    alu_i_rs2 = rs2;
    alu_i_imm = imm;
    alu_i_tag = tag;
    alu_i_valid = 1;
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [2:0] m, input logic [3:0] f,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] exp);
    drive(op, m, f, rs1, rs2, imm, 5'(op));
    step();
    check({name, "_lat"}, 64'(alu_o_valid), 64'd1);
    check(name, alu_o_wbck_wdat, exp);
    alu_i_valid = 0;
  endtask

  initial begin
    alu_i_pc = 32'h1000;
    #12;
    check("rst_valid", 64'(alu_o_valid), 64'd0);
    check("rst_ready", 64'(alu_i_ready), 64'd1);
    check("rst_wdat", alu_o_wbck_wdat, 64'd0);
    step();
    rst = 0;
    step();
    issue("add_wrap", 0, 3'b000, 0, '1, 64'd1, 0, 64'd0);
    issue("addw_wrap", 0, 3'b100, 0, 64'hFFFF_FFFF, 64'd1, 0, 64'd0);
    issue("sraw", 5, 3'b101, 0, 64'h8000_0000, 0, 64'd4, 64'hFFFF_FFFF_F800_0000);
    issue("slt", 8, 3'b000, 0, '1, 64'd1, 0, 64'd1);
    issue("sltu", 9, 3'b000, 0, '1, 64'd1, 0, 64'd0);
    issue("illegal", 12, 3'b000, 0, 64'd7, 64'd9, 0, 64'd0);
    check("ill_flags", 64'({alu_o_illegal, alu_o_wbck_err}), 64'b11);
    issue("nop", 0, 3'b000, 4'b1000, 64'd5, 64'd6, 0, 64'd0);
    issue("ecall", 0, 3'b000, 4'b0100, 64'd1, 64'd1, 0, 64'd2);
    check("ecall_err", 64'({alu_o_cmt_ecall, alu_o_wbck_err}), 64'b11);
    issue("lui", 10, 3'b001, 0, 64'd3, 0, 64'h1234_5000, 64'h1234_5000);
    issue("pc_add", 0, 3'b011, 0, 64'd99, 0, 64'd4, 64'h1004);
    issue("subw", 1, 3'b100, 0, 64'd0, 64'd1, 0, '1);
    issue("srlw", 4, 3'b100, 0, 64'hFFFF_FFFF_8000_0000, 64'd4, 0, 64'h0800_0000);
    issue("sra64", 5, 3'b000, 0, 64'h8000_0000_0000_0000, 64'd63, 0, '1);
    issue("sll64", 3, 3'b000, 0, 64'd1, 64'd63, 0, 64'h8000_0000_0000_0000);
    issue("sll_mask", 3, 3'b000, 0, 64'd1, 64'd65, 0, 64'd2);
    issue("xorw", 2, 3'b100, 0, 64'hF0F0_0000_0000_00FF, 64'hFF, 0, 64'hF0F0_0000_0000_0000);
    issue("or", 6, 3'b000, 0, 64'hF0, 64'h0F, 0, 64'hFF);
    issue("and", 7, 3'b000, 0, 64'hF0, 64'h3C, 0, 64'h30);
    step();
    alu_o_ready = 0;
    drive(0, 0, 0, 64'd1, 64'd1, 0, 5'd1);
    step();
    drive(0, 0, 0, 64'd2, 64'd2, 0, 5'd2);
    step();
    alu_i_valid = 0;
    check("full_rdy", 64'(alu_i_ready), 64'd0);
    check("head_tag", 64'(alu_o_tag), 64'd1);
    step();
    check("head_hold", 64'(alu_o_tag), 64'd1);
    drive(0, 0, 0, 64'd3, 64'd3, 0, 5'd3);
    alu_o_ready = 1;
    #1;
    check("full_rdy_pop", 64'(alu_i_ready), 64'd1);
    step();
    alu_i_valid = 0;
    check("after_pp_tag", 64'(alu_o_tag), 64'd2);
    step();
    step();
    check("drained_bp", 64'(q.size()), 64'd0);
    alu_o_ready = 0;
    drive(0, 0, 0, 64'd4, 64'd4, 0, 5'd4);
    step();
    drive(0, 0, 0, 64'd5, 64'd5, 0, 5'd5);
    step();
    drive(0, 0, 0, 64'd6, 64'd6, 0, 5'd6);
    alu_flush = 1;
    step();
    alu_flush = 0;
    alu_i_valid = 0;
    check("flush_valid", 64'(alu_o_valid), 64'd0);
    check("flush_rdy", 64'(alu_i_ready), 64'd1);
    drive(0, 0, 0, 64'd7, 64'd7, 0, 5'd7);
    step();
    alu_i_valid = 0;
    check("held_one", 64'(alu_o_valid), 64'd1);
    #1 rst = 1;
    q.delete();
    #1;
    check("arst_valid", 64'(alu_o_valid), 64'd0);
    check("arst_rdy", 64'(alu_i_ready), 64'd1);
    check("arst_wdat", alu_o_wbck_wdat, 64'd0);
    rst = 0;
    alu_o_ready = 1;
    issue("post_rst", 0, 3'b000, 0, 64'd2, 64'd3, 0, 64'd5);
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 3'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
            {$urandom, $urandom}, $urandom_range(0, 1) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom));
      alu_i_pc = $urandom;
      alu_i_valid = $urandom_range(0, 3) != 0;
      alu_o_ready = $urandom_range(0, 3) != 0;
      alu_flush = $urandom_range(0, 40) == 0;
      step();
    end
    alu_i_valid = 0;
    alu_flush = 0;
    alu_o_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    check("drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
